// File: rtl/pong_ball_ctrl.sv
// Pong ball engine: moves the ball once per frame_tick, bounces it off walls and
// paddles, awards points on a miss and sequences serve / hold / game-over.
module pong_ball_ctrl #(
  parameter int unsigned SCREEN_W    = 640,
  parameter int unsigned SCREEN_H    = 480,
  parameter int unsigned BALL_HALF   = 5,
  parameter int unsigned SPEED_X     = 3,
  parameter int unsigned SPEED_Y     = 2,
  parameter int unsigned LPAD_FACE_X = 100,
  parameter int unsigned RPAD_FACE_X = 540,
  parameter int unsigned PAD_HALF    = 20,
  parameter int unsigned HOLD_FRAMES = 60,
  parameter int unsigned WIN_SCORE   = 9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       serve,
  input  logic [9:0] left_pad_y_pos,
  input  logic [9:0] right_pad_y_pos,
  output logic [9:0] ball_x_pos,
  output logic [9:0] ball_y_pos,
  output logic [3:0] left_score,
  output logic [3:0] right_score,
  output logic       paddle_hit,
  output logic       point_scored,
  output logic       game_over
);

  localparam int unsigned HoldW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;

  localparam logic [9:0]       CenterX  = 10'(SCREEN_W / 2);
  localparam logic [9:0]       CenterY  = 10'(SCREEN_H / 2);
  localparam logic [10:0]      Bh       = 11'(BALL_HALF);
  localparam logic [10:0]      SpdX     = 11'(SPEED_X);
  localparam logic [10:0]      SpdY     = 11'(SPEED_Y);
  localparam logic [10:0]      LFace    = 11'(LPAD_FACE_X);
  localparam logic [10:0]      RFace    = 11'(RPAD_FACE_X);
  localparam logic [10:0]      XMax     = 11'(SCREEN_W - 1 - BALL_HALF);
  localparam logic [10:0]      YMax     = 11'(SCREEN_H - 1 - BALL_HALF);
  localparam logic [10:0]      PadReach = 11'(PAD_HALF + BALL_HALF);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD_FRAMES - 1);
  localparam logic [3:0]       WinVal   = 4'(WIN_SCORE);

  typedef enum logic [1:0] {StIdle, StPlay, StScored, StGameOver} state_e;

  state_e           state_q;
  logic             dir_right_q;
  logic             dir_down_q;
  logic [HoldW-1:0] hold_q;

  logic [10:0] x, y, lpad, rpad, dy_l, dy_r;
  logic [9:0]  x_next, y_next;
  logic        dir_down_next;
  logic        overlap_l, overlap_r, r_face, l_face, r_miss, l_miss;
  logic [3:0]  ls_inc, rs_inc;

  assign x    = {1'b0, ball_x_pos};
  assign y    = {1'b0, ball_y_pos};
  assign lpad = {1'b0, left_pad_y_pos};
  assign rpad = {1'b0, right_pad_y_pos};

  // Absolute differences keep the overlap test free of underflow.
  assign dy_l      = (y >= lpad) ? y - lpad : lpad - y;
  assign dy_r      = (y >= rpad) ? y - rpad : rpad - y;
  assign overlap_l = (dy_l <= PadReach);
  assign overlap_r = (dy_r <= PadReach);

  // A face only bounces a ball arriving from the open side of the paddle.
  assign r_face = dir_right_q && (x + Bh < RFace) && (x + Bh + SpdX >= RFace) && overlap_r;
  assign l_face = !dir_right_q && (x > LFace + Bh) && (x <= LFace + Bh + SpdX) && overlap_l;
  assign r_miss = dir_right_q && !r_face && (x + SpdX > XMax);
  assign l_miss = !dir_right_q && !l_face && (x < Bh + SpdX);

  assign ls_inc = left_score + 4'd1;
  assign rs_inc = right_score + 4'd1;

  always_comb begin
    x_next = 10'(x + SpdX);
    if (r_face) begin
      x_next = 10'(RFace - Bh - 11'd1);
    end else if (l_face) begin
      x_next = 10'(LFace + Bh + 11'd1);
    end else if (!dir_right_q) begin
      x_next = 10'(x - SpdX);
    end
  end

  always_comb begin
    y_next        = 10'(y + SpdY);
    dir_down_next = dir_down_q;
    if (!dir_down_q) begin
      if (y < Bh + SpdY) begin
        y_next        = 10'(Bh);
        dir_down_next = 1'b1;
      end else begin
        y_next = 10'(y - SpdY);
      end
    end else if (y + SpdY > YMax) begin
      y_next        = 10'(YMax);
      dir_down_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      ball_x_pos   <= CenterX;
      ball_y_pos   <= CenterY;
      dir_right_q  <= 1'b1;
      dir_down_q   <= 1'b1;
      left_score   <= '0;
      right_score  <= '0;
      paddle_hit   <= 1'b0;
      point_scored <= 1'b0;
      game_over    <= 1'b0;
      hold_q       <= '0;
    end else begin
      paddle_hit   <= 1'b0;
      point_scored <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (serve) state_q <= StPlay;
        end
        StPlay: begin
          if (frame_tick) begin
            if (r_miss || l_miss) begin
              // The y step of this tick is dropped; dir_y carries into the next serve.
              point_scored <= 1'b1;
              ball_x_pos   <= CenterX;
              ball_y_pos   <= CenterY;
              dir_right_q  <= r_miss;
              hold_q       <= '0;
              if (r_miss) begin
                left_score <= ls_inc;
                game_over  <= (ls_inc == WinVal);
                state_q    <= (ls_inc == WinVal) ? StGameOver : StScored;
              end else begin
                right_score <= rs_inc;
                game_over   <= (rs_inc == WinVal);
                state_q     <= (rs_inc == WinVal) ? StGameOver : StScored;
              end
            end else begin
              ball_x_pos <= x_next;
              ball_y_pos <= y_next;
              dir_down_q <= dir_down_next;
              if (r_face || l_face) begin
                dir_right_q <= l_face;
                paddle_hit  <= 1'b1;
              end
            end
          end
        end
        StScored: begin
          if (frame_tick) begin
            if (hold_q == HoldLast) begin
              state_q <= StPlay;
              hold_q  <= '0;
            end else begin
              hold_q <= hold_q + HoldW'(1);
            end
          end
        end
        StGameOver: begin
          if (serve) begin
            state_q     <= StPlay;
            left_score  <= '0;
            right_score <= '0;
            game_over   <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_pong_ball_ctrl.sv
// Scoreboard bench for pong_ball_ctrl: directed rallies with hand-computed ball
// positions, scores and pulses; a monitor compares one cycle after each pushed vector.
module tb_pong_ball_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       frame_tick = 1'b0;
  logic       serve = 1'b0;
  logic [9:0] left_pad_y_pos = 10'd1000;
  logic [9:0] right_pad_y_pos = 10'd1000;
  logic [9:0] ball_x_pos, ball_y_pos;
  logic [3:0] left_score, right_score;
  logic       paddle_hit, point_scored, game_over;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic [3:0] ls;
    logic [3:0] rs;
    logic       ph;
    logic       ps;
    logic       go;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_vec = 0;
  int    n_bad = 0;

  pong_ball_ctrl dut (
    .clk             (clk),
    .reset           (reset),
    .frame_tick      (frame_tick),
    .serve           (serve),
    .left_pad_y_pos  (left_pad_y_pos),
    .right_pad_y_pos (right_pad_y_pos),
    .ball_x_pos      (ball_x_pos),
    .ball_y_pos      (ball_y_pos),
    .left_score      (left_score),
    .right_score     (right_score),
    .paddle_hit      (paddle_hit),
    .point_scored    (point_scored),
    .game_over       (game_over)
  );

  always #5 clk = ~clk;

  // Drive inputs for the coming posedge.
  task automatic step(input logic ft, input logic sv);
    @(negedge clk);
    reset      = 1'b0;
    frame_tick = ft;
    serve      = sv;
  endtask

  task automatic do_reset(input logic ft);
    @(negedge clk);
    reset      = 1'b1;
    frame_tick = ft;
    serve      = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0);
  endtask

  // Expectation for the outputs after the posedge that follows the last drive.
  task automatic chk(input string nm, input int x, input int y, input int ls, input int rs,
                     input logic ph, input logic ps, input logic go);
    exp_t e;
    e.x  = 10'(x);
    e.y  = 10'(y);
    e.ls = 4'(ls);
    e.rs = 4'(rs);
    e.ph = ph;
    e.ps = ps;
    e.go = go;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  initial begin : monitor
    exp_t  e;
    exp_t  a;
    string nm;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        a  = '{x: ball_x_pos, y: ball_y_pos, ls: left_score, rs: right_score,
               ph: paddle_hit, ps: point_scored, go: game_over};
        n_vec++;
        if (a !== e) begin
          n_bad++;
          $display("FAIL %s: got x=%0d y=%0d ls=%0d rs=%0d hit=%b pt=%b go=%b, want x=%0d y=%0d ls=%0d rs=%0d hit=%b pt=%b go=%b",
                   nm, a.x, a.y, a.ls, a.rs, a.ph, a.ps, a.go,
                   e.x, e.y, e.ls, e.rs, e.ph, e.ps, e.go);
        end
      end
    end
  end

  initial begin : stimulus
    // Reset state and serve-with-tick (serve taken, no move).
    do_reset(1'b0); chk("reset", 320, 240, 0, 0, 0, 0, 0);
    step(1, 1);     chk("serve_no_move", 320, 240, 0, 0, 0, 0, 0);
    step(1, 0);     chk("tick1", 323, 242, 0, 0, 0, 0, 0);
    step(1, 0);     chk("tick2", 326, 244, 0, 0, 0, 0, 0);
    step(1, 0);     chk("tick3", 329, 246, 0, 0, 0, 0, 0);

    // Right paddle one pixel out of reach: no bounce, left scores, 60-tick hold.
    right_pad_y_pos = 10'd408;
    ticks(68);
    step(1, 0);     chk("rpad_out_of_reach", 536, 384, 0, 0, 0, 0, 0);
    ticks(31);
    step(1, 0);     chk("last_before_miss", 632, 448, 0, 0, 0, 0, 0);
    step(1, 0);     chk("left_scores", 320, 240, 1, 0, 0, 1, 0);
    step(0, 0);     chk("point_pulse_end", 320, 240, 1, 0, 0, 0, 0);
    ticks(58);
    step(1, 0);     chk("hold_59", 320, 240, 1, 0, 0, 0, 0);
    step(1, 0);     chk("hold_60", 320, 240, 1, 0, 0, 0, 0);
    step(1, 0);     chk("resume_right", 323, 242, 1, 0, 0, 0, 0);

    // Right paddle exactly at reach: bounce to 534.
    right_pad_y_pos = 10'd407;
    ticks(70);
    step(1, 0);     chk("rpad_bounce", 534, 384, 1, 0, 1, 0, 0);
    step(0, 0);     chk("hit_pulse_end", 534, 384, 1, 0, 0, 0, 0);
    right_pad_y_pos = 10'd1000;
    step(1, 0);     chk("moving_left", 531, 386, 1, 0, 0, 0, 0);

    // Bottom wall flip on the way, then a miss past the left paddle.
    ticks(174);
    step(1, 0);     chk("left_side_pre_miss", 6, 214, 1, 0, 0, 0, 0);
    step(1, 0);     chk("right_scores", 320, 240, 1, 1, 0, 1, 0);
    ticks(60);

    // Serve leftward and up; left paddle bounce, then top wall clamp.
    left_pad_y_pos = 10'd98;
    ticks(71);
    step(1, 0);     chk("lpad_bounce", 106, 96, 1, 1, 1, 0, 0);
    ticks(44);
    step(1, 0);     chk("near_top", 241, 6, 1, 1, 0, 0, 0);
    step(1, 0);     chk("top_clamp", 244, 5, 1, 1, 0, 0, 0);
    step(1, 0);     chk("top_flip", 247, 7, 1, 1, 0, 0, 0);

    // Reset mid-play with a frame tick pending.
    do_reset(1'b1); chk("reset_mid_play", 320, 240, 0, 0, 0, 0, 0);

    // Left wins nine straight points.
    left_pad_y_pos = 10'd1000;
    step(0, 1);     chk("serve_idle", 320, 240, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 9; k++) begin
      ticks(104);
      step(1, 0);   chk($sformatf("point_%0d", k), 320, 240, k, 0, 0, 1, k == 9);
      if (k < 9) ticks(60);
    end
    step(1, 0);     chk("frozen", 320, 240, 9, 0, 0, 0, 1);
    step(1, 1);     chk("restart_clears", 320, 240, 0, 0, 0, 0, 0);
    step(1, 0);     chk("restart_moves", 323, 242, 0, 0, 0, 0, 0);
    step(0, 0);

    @(posedge clk);
    #3;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d vectors left unchecked, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
